// File: rtl/axis_output_packer.sv
// Serializes each wide accelerator output beat into R narrow AXI-Stream beats,
// least-significant slice first, with a single wide-beat holding register.
module axis_output_packer #(
    parameter int S_DATA_WIDTH = 256,
    parameter int M_DATA_WIDTH = 64,
    parameter int TUSER_WIDTH  = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]    m_axis_tuser
);
    localparam int R  = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                   state, state_nxt;
    logic [S_DATA_WIDTH-1:0]  data_buf, data_buf_nxt;
    logic                     last_r, last_nxt;
    logic [TUSER_WIDTH-1:0]   user_r, user_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic                     full, at_last, s_fire, m_fire;
    logic [R-1:0][M_DATA_WIDTH-1:0] slices;

    assign full    = (state == FULL);
    assign at_last = (cnt == CNT_LAST);

    // Ready looks through to m_axis_tready on the final slice so a new wide
    // beat can be loaded in the same cycle the old one drains.
    assign s_axis_tready = ~areset & (~full | (at_last & m_axis_tready));
    assign m_axis_tvalid = ~areset & full;
    assign s_fire        = s_axis_tvalid & s_axis_tready;
    assign m_fire        = m_axis_tvalid & m_axis_tready;

    assign slices        = data_buf;
    assign m_axis_tdata  = areset ? '0 : slices[cnt];
    assign m_axis_tlast  = m_axis_tvalid & last_r & at_last;
    assign m_axis_tuser  = areset ? '0 : user_r;
    assign m_axis_tkeep  = '1;

    always_comb begin
        state_nxt    = state;
        data_buf_nxt = data_buf;
        last_nxt     = last_r;
        user_nxt     = user_r;
        cnt_nxt      = cnt;
        case (state)
            EMPTY: begin
                if (s_fire) begin
                    data_buf_nxt = s_axis_tdata;
                    last_nxt     = s_axis_tlast;
                    user_nxt     = s_axis_tuser;
                    cnt_nxt      = '0;
                    state_nxt    = FULL;
                end
            end
            FULL: begin
                if (m_fire) begin
                    if (!at_last) begin
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        cnt_nxt = '0;
                        if (s_fire) begin
                            data_buf_nxt = s_axis_tdata;
                            last_nxt     = s_axis_tlast;
                            user_nxt     = s_axis_tuser;
                        end else begin
                            state_nxt = EMPTY;
                        end
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= EMPTY;
            data_buf <= '0;
            last_r   <= 1'b0;
            user_r   <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            data_buf <= data_buf_nxt;
            last_r   <= last_nxt;
            user_r   <= user_nxt;
            cnt      <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_axis_output_packer.sv
// Directed bench for axis_output_packer: hand vectors plus a slice-queue model.
module tb_axis_output_packer;
    localparam int SW = 256;
    localparam int MW = 64;
    localparam int UW = 8;
    localparam logic [SW-1:0] D1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [SW-1:0] D2 = {{16{4'hd}}, {16{4'hc}}, {16{4'hb}}, {16{4'ha}}};

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_axis_tready, s_axis_tvalid, s_axis_tlast;
    logic [SW-1:0] s_axis_tdata;
    logic [UW-1:0] s_axis_tuser;
    logic          m_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [MW-1:0] m_axis_tdata;
    logic [MW/8-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;

    always #5 aclk = ~aclk;

    axis_output_packer #(.S_DATA_WIDTH(SW), .M_DATA_WIDTH(MW), .TUSER_WIDTH(UW)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser)
    );

    typedef struct {
        logic [MW-1:0] d;
        logic          l;
        logic [UW-1:0] u;
    } slice_t;

    slice_t        q[$];
    slice_t        e;
    int            n_tests = 0, n_fail = 0;
    int            n_out, n_in, n_last_out, n_last_in, cyc, first_out_cyc, last_out_cyc;
    bit            s_fired, stall_prev;
    logic [MW-1:0] pd;
    logic          pl;
    logic [UW-1:0] pu;
    logic [MW-1:0] exp1[4];
    int            k, o;

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] rand_wide();
        logic [SW-1:0] v;
        for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clr();
        n_out = 0; n_in = 0; n_last_out = 0; n_last_in = 0;
        first_out_cyc = -1; last_out_cyc = -1;
    endtask

    // One clock: check outputs against the queue model, then advance to the next negedge.
    task automatic tick();
        #1;
        if (stall_prev) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_data", m_axis_tdata, pd);
            chk("stall_last", m_axis_tlast, pl);
            chk("stall_user", m_axis_tuser, pu);
        end
        chk("m_valid", m_axis_tvalid, q.size() != 0);
        chk("s_ready", s_axis_tready, (q.size() == 0) || (q.size() == 1 && m_axis_tready));
        chk("keep", m_axis_tkeep, 8'hFF);
        if (m_axis_tvalid && m_axis_tready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_data", m_axis_tdata, e.d);
                chk("out_last", m_axis_tlast, e.l);
                chk("out_user", m_axis_tuser, e.u);
            end
            n_out++;
            if (m_axis_tlast) n_last_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
        end
        s_fired = s_axis_tvalid && s_axis_tready;
        if (s_fired) begin
            for (int i = 0; i < SW / MW; i++)
                q.push_back('{d: s_axis_tdata[i*MW +: MW], l: s_axis_tlast && (i == SW/MW - 1), u: s_axis_tuser});
            n_in++;
            if (s_axis_tlast) n_last_in++;
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        pd = m_axis_tdata; pl = m_axis_tlast; pu = m_axis_tuser;
        @(negedge aclk);
        cyc++;
    endtask

    initial begin
        exp1[0] = 64'h1111111111111111; exp1[1] = 64'h2222222222222222;
        exp1[2] = 64'h3333333333333333; exp1[3] = 64'h4444444444444444;
        cyc = 0; stall_prev = 0; clr();
        areset = 1; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0;
        s_axis_tuser = '0; m_axis_tready = 0;

        // Reset state
        repeat (2) @(negedge aclk);
        #1;
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_data", m_axis_tdata, 0);
        chk("rst_last", m_axis_tlast, 0);
        chk("rst_user", m_axis_tuser, 0);
        @(negedge aclk);
        areset = 0;
        #1;
        chk("idle_s_ready", s_axis_tready, 1);
        chk("idle_m_valid", m_axis_tvalid, 0);

        // 1: single wide beat, first slice one cycle after acceptance
        m_axis_tready = 1; s_axis_tvalid = 1; s_axis_tdata = D1; s_axis_tlast = 1; s_axis_tuser = 8'h11;
        tick();
        s_axis_tvalid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s1_valid", m_axis_tvalid, 1);
            chk("s1_data", m_axis_tdata, exp1[i]);
            chk("s1_last", m_axis_tlast, i == 3);
            tick();
        end
        #1;
        chk("s1_drained", m_axis_tvalid, 0);

        // 2: eight back-to-back wide beats, no bubbles
        clr(); k = 0;
        s_axis_tvalid = 1; s_axis_tdata = rand_wide(); s_axis_tlast = 0; s_axis_tuser = 8'h22;
        for (int c = 0; c < 60 && n_out < 32; c++) begin
            tick();
            if (s_fired) begin
                k++;
                if (k == 8) s_axis_tvalid = 0;
                else begin s_axis_tdata = rand_wide(); s_axis_tlast = (k == 7); end
            end
        end
        chk("s2_in", n_in, 8);
        chk("s2_out", n_out, 32);
        chk("s2_lasts", n_last_out, 1);
        chk("s2_span", last_out_cyc - first_out_cyc, 31);

        // 3: backpressure on a single beat with tuser 0x5A
        repeat (2) tick();
        clr(); o = 0;
        s_axis_tvalid = 1; s_axis_tdata = D1; s_axis_tlast = 1; s_axis_tuser = 8'h5A; m_axis_tready = 1;
        tick();
        s_axis_tvalid = 0;
        for (int j = 0; j < 40 && o < 4; j++) begin
            case (j)
                0, 3, 5, 8, 9, 11: m_axis_tready = 1;
                1, 2, 4, 6, 7, 10: m_axis_tready = 0;
                default:           m_axis_tready = 1'($urandom_range(1));
            endcase
            #1;
            if (m_axis_tvalid) chk("s3_user", m_axis_tuser, 8'h5A);
            if (m_axis_tvalid && m_axis_tready) begin
                chk("s3_data", m_axis_tdata, exp1[o]);
                chk("s3_last", m_axis_tlast, o == 3);
                o++;
            end
            tick();
        end
        chk("s3_count", o, 4);

        // 4: input beat every 7 cycles, block idles in between
        m_axis_tready = 1; clr();
        for (int b = 0; b < 4; b++) begin
            s_axis_tvalid = 1; s_axis_tdata = rand_wide(); s_axis_tlast = (b == 3); s_axis_tuser = 8'(b);
            tick();
            s_axis_tvalid = 0;
            repeat (6) tick();
            #1;
            chk("s4_gap_valid", m_axis_tvalid, 0);
            chk("s4_gap_ready", s_axis_tready, 1);
        end
        chk("s4_out", n_out, 16);

        // 5: reset after the second slice discards the rest
        s_axis_tvalid = 1; s_axis_tdata = D2; s_axis_tlast = 1; s_axis_tuser = 8'h33;
        tick();
        s_axis_tvalid = 0;
        tick(); tick();
        areset = 1;
        #1;
        chk("s5_rst_valid", m_axis_tvalid, 0);
        chk("s5_rst_ready", s_axis_tready, 0);
        @(negedge aclk);
        areset = 0; q.delete(); stall_prev = 0;
        #1;
        chk("s5_post_valid", m_axis_tvalid, 0);
        chk("s5_post_data", m_axis_tdata, 0);
        chk("s5_post_last", m_axis_tlast, 0);
        chk("s5_post_user", m_axis_tuser, 0);
        s_axis_tvalid = 1; s_axis_tdata = D1; s_axis_tlast = 1; s_axis_tuser = 8'h44;
        tick();
        s_axis_tvalid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s5_data", m_axis_tdata, exp1[i]);
            tick();
        end

        // 6: 1000 random beats with random valid/ready
        clr(); k = 0; s_axis_tvalid = 0;
        for (int c = 0; c < 30000 && n_out < 4000; c++) begin
            if (!s_axis_tvalid && k < 1000 && $urandom_range(1) == 1) begin
                s_axis_tvalid = 1; s_axis_tdata = rand_wide();
                s_axis_tlast = 1'($urandom_range(1)); s_axis_tuser = 8'($urandom);
            end
            m_axis_tready = 1'($urandom_range(1));
            tick();
            if (s_fired) begin k++; s_axis_tvalid = 0; end
        end
        chk("s6_in", n_in, 1000);
        chk("s6_out", n_out, 4000);
        chk("s6_lasts", n_last_out, n_last_in);
        chk("s6_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
